// File: rtl/qxcom_cmd_rsp.sv
// rtl/qxcom_cmd_rsp.sv - XCOM four-phase command responder with show-ahead command FIFO
// Optional 2-flop request synchronizer enabled by defining QXCOM_RSP_SYNC_EN.
module qxcom_cmd_rsp #(
   parameter int DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        loc_req_i,
   input  logic        net_req_i,
   input  logic [7:0]  req_op_i,
   input  logic [31:0] req_dt_i,
   output logic        ack_o,
   output logic        cmd_vld_o,
   input  logic        cmd_rdy_i,
   output logic        cmd_net_o,
   output logic [7:0]  cmd_op_o,
   output logic [31:0] cmd_dt_o,
   output logic        err_o,
   output logic [4:0]  fifo_cnt_do,
   output logic [3:0]  cmd_cnt_do
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

   state_t      state_q, state_d;
   logic        loc_s, net_s, req_s;
   logic        push, pop, set_err;
   logic        full, empty;
   logic [AW:0] wr_ptr, rd_ptr, fill;
   logic [3:0]  cmd_cnt_q;
   logic        err_q;

   logic        mem_net [DEPTH];
   logic [7:0]  mem_op  [DEPTH];
   logic [31:0] mem_dt  [DEPTH];

`ifdef QXCOM_RSP_SYNC_EN
   (* ASYNC_REG = "TRUE" *) logic [1:0] loc_sync;
   (* ASYNC_REG = "TRUE" *) logic [1:0] net_sync;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         loc_sync <= 2'b00;
         net_sync <= 2'b00;
      end else begin
         loc_sync <= {loc_sync[0], loc_req_i};
         net_sync <= {net_sync[0], net_req_i};
      end
   end

   assign loc_s = loc_sync[1];
   assign net_s = net_sync[1];
`else
   assign loc_s = loc_req_i;
   assign net_s = net_req_i;
`endif

   assign req_s = loc_s | net_s;

   // Full/empty come from the registered pointers, so a pop cannot make room for a same-cycle push.
   assign fill  = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop   = !empty && cmd_rdy_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      set_err = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_s) begin
               if (!full) begin
                  push    = 1'b1;
                  state_d = ACK;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (!req_s) begin
               set_err = 1'b1;
               state_d = IDLE;
            end else if (!full) begin
               push    = 1'b1;
               state_d = ACK;
            end
         end
         ACK: begin
            if (!req_s) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Simultaneous local and network requests are a protocol violation; local wins.
      if (push && loc_s && net_s) begin
         set_err = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_net[wr_ptr[AW-1:0]] <= net_s & ~loc_s;
         mem_op[wr_ptr[AW-1:0]]  <= req_op_i;
         mem_dt[wr_ptr[AW-1:0]]  <= req_dt_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cmd_cnt_q <= 4'd0;
         err_q     <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr    <= wr_ptr + {{AW{1'b0}}, 1'b1};
            cmd_cnt_q <= cmd_cnt_q + 4'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
         end
         if (set_err) begin
            err_q <= 1'b1;
         end
      end
   end

   assign ack_o       = (state_q == ACK);
   assign cmd_vld_o   = !empty;
   assign cmd_net_o   = empty ? 1'b0  : mem_net[rd_ptr[AW-1:0]];
   assign cmd_op_o    = empty ? 8'h00 : mem_op[rd_ptr[AW-1:0]];
   assign cmd_dt_o    = empty ? 32'h0 : mem_dt[rd_ptr[AW-1:0]];
   assign err_o       = err_q;
   assign fifo_cnt_do = 5'(fill);
   assign cmd_cnt_do  = cmd_cnt_q;

endmodule

// File: tb/tb_qxcom_cmd_rsp.sv
// tb/tb_qxcom_cmd_rsp.sv - randomized self-checking bench for qxcom_cmd_rsp against a transaction-level queue model
module tb_qxcom_cmd_rsp;
   localparam int DEPTH = 4;
`ifdef QXCOM_RSP_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic        clk;
   logic        rst;
   logic        loc_req, net_req;
   logic [7:0]  req_op;
   logic [31:0] req_dt;
   logic        ack, cmd_vld, cmd_rdy, cmd_net, err;
   logic [7:0]  cmd_op;
   logic [31:0] cmd_dt;
   logic [4:0]  fifo_cnt;
   logic [3:0]  cmd_cnt;

   qxcom_cmd_rsp #(.DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_i(rst),
      .loc_req_i(loc_req), .net_req_i(net_req),
      .req_op_i(req_op), .req_dt_i(req_dt),
      .ack_o(ack), .cmd_vld_o(cmd_vld), .cmd_rdy_i(cmd_rdy),
      .cmd_net_o(cmd_net), .cmd_op_o(cmd_op), .cmd_dt_o(cmd_dt),
      .err_o(err), .fifo_cnt_do(fifo_cnt), .cmd_cnt_do(cmd_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        net;
      logic [7:0]  op;
      logic [31:0] dt;
   } entry_t;

   // Transaction-level model: queued commands, whether the live request is acked or stalled.
   entry_t q[$];
   bit     acked, waiting, m_err;
   int     m_cnt;
   logic   h1_loc, h1_net, h2_loc, h2_net;
   int     rdy_pct;
   int     n_checks, n_pass;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic check_outputs();
      check("ack", ack, acked);
      if (q.size() > 0) begin
         check("vld", cmd_vld, 1);
         check("head_net", cmd_net, q[0].net);
         check("head_op", cmd_op, q[0].op);
         check("head_dt", cmd_dt, q[0].dt);
      end else begin
         check("vld", cmd_vld, 0);
         check("idle_net", cmd_net, 0);
         check("idle_op", cmd_op, 0);
         check("idle_dt", cmd_dt, 0);
      end
      check("fifo_cnt", fifo_cnt, q.size());
      check("cmd_cnt", cmd_cnt, m_cnt);
      check("err", err, m_err);
   endtask

   task automatic cycle();
      logic   s_loc, s_net, s_req, room, pop;
      entry_t e;
      if (rdy_pct >= 0) cmd_rdy = ($urandom_range(0, 99) < rdy_pct);
      if (LAT == 3) begin
         s_loc = h2_loc;
         s_net = h2_net;
      end else begin
         s_loc = loc_req;
         s_net = net_req;
      end
      h2_loc = h1_loc; h2_net = h1_net;
      h1_loc = loc_req; h1_net = net_req;
      s_req = s_loc | s_net;
      room  = q.size() < DEPTH;
      pop   = (q.size() > 0) && cmd_rdy;
      e.net = s_net & ~s_loc;
      e.op  = req_op;
      e.dt  = req_dt;
      @(posedge clk); #1;
      if (pop) void'(q.pop_front());
      if (acked) begin
         if (!s_req) acked = 0;
      end else if (s_req && room) begin
         q.push_back(e);
         m_cnt   = (m_cnt + 1) % 16;
         acked   = 1;
         waiting = 0;
         if (s_loc && s_net) m_err = 1;
      end else if (s_req) begin
         waiting = 1;
      end else if (waiting) begin
         m_err   = 1;
         waiting = 0;
      end
      check_outputs();
   endtask

   task automatic apply_reset();
      rst = 1; loc_req = 0; net_req = 0; cmd_rdy = 0;
      @(posedge clk); #1;
      q.delete();
      acked = 0; waiting = 0; m_err = 0; m_cnt = 0;
      h1_loc = 0; h1_net = 0; h2_loc = 0; h2_net = 0;
      check_outputs();
      rst = 0;
   endtask

   task automatic release_req();
      int n;
      loc_req = 0; net_req = 0;
      n = 0;
      while ((acked || waiting || n < LAT) && n < 32) begin
         cycle();
         n++;
      end
      req_op = 8'($urandom);
      req_dt = $urandom;
   endtask

   task automatic handshake(input logic loc, input logic net, input logic [7:0] op,
                            input logic [31:0] dt, input int hold_max);
      int n;
      loc_req = loc; net_req = net; req_op = op; req_dt = dt;
      n = 0;
      while (!acked && n < hold_max) begin
         cycle();
         n++;
      end
      if (acked) repeat ($urandom_range(0, 2)) cycle();
      release_req();
   endtask

   initial begin
      int cnt_before;
      int sel;
      n_checks = 0; n_pass = 0;
      rst = 1; loc_req = 0; net_req = 0; cmd_rdy = 0; req_op = 0; req_dt = 0;
      rdy_pct = -1;
      apply_reset();
      apply_reset();

      // Single local command drained immediately
      cmd_rdy = 1;
      handshake(1'b1, 1'b0, 8'h4A, 32'hDEADBEEF, LAT + 4);
      check("t1_cmd_cnt", cmd_cnt, 1);

      // Fill to DEPTH, fifth request stalls until one pop frees space
      cmd_rdy = 0;
      repeat (DEPTH) handshake(1'b0, 1'b1, 8'($urandom), $urandom, LAT + 4);
      check("t2_full_cnt", fifo_cnt, DEPTH);
      loc_req = 0; net_req = 1; req_op = 8'hC3; req_dt = 32'h5555AAAA;
      repeat (LAT + 3) cycle();
      check("t2_wait_ack", ack, 0);
      cmd_rdy = 1;
      cycle();
      cmd_rdy = 0;
      cycle();
      check("t2_ack5", ack, 1);
      release_req();
      cmd_rdy = 1;
      repeat (DEPTH + 2) cycle();
      check("t2_drained", fifo_cnt, 0);

      // Abort while stalled on a full FIFO
      cmd_rdy = 0;
      repeat (DEPTH) handshake(1'b1, 1'b0, 8'($urandom), $urandom, LAT + 4);
      cnt_before = m_cnt;
      loc_req = 1; net_req = 0; req_op = 8'h77; req_dt = 32'h12345678;
      repeat (LAT + 2) cycle();
      release_req();
      check("t4_abort_err", err, 1);
      check("t4_abort_cnt", cmd_cnt, cnt_before);
      check("t4_abort_fill", fifo_cnt, DEPTH);

      apply_reset();
      check("rst_err_clear", err, 0);

      // Both requests at once: local entry, sticky error
      cmd_rdy = 1;
      handshake(1'b1, 1'b1, 8'h11, $urandom, LAT + 4);
      check("t3_err", err, 1);
      repeat (3) handshake(1'b0, 1'b1, 8'($urandom), $urandom, LAT + 4);
      check("t3_err_sticky", err, 1);

      // Reset while acking with two entries queued
      apply_reset();
      cmd_rdy = 0;
      handshake(1'b0, 1'b1, 8'hA1, 32'h1, LAT + 4);
      loc_req = 1; net_req = 0; req_op = 8'hB2; req_dt = 32'h2;
      repeat (LAT) cycle();
      check("t5_pre_ack", ack, 1);
      check("t5_pre_cnt", fifo_cnt, 2);
      apply_reset();
      check("t5_ack", ack, 0);
      check("t5_vld", cmd_vld, 0);
      check("t5_cnt", fifo_cnt, 0);

      // Random traffic
      for (int i = 0; i < 150; i++) begin
         rdy_pct = $urandom_range(0, 100);
         sel = $urandom_range(0, 9);
         handshake(sel == 0, sel != 1 && sel[0] == 1'b0 ? 1'b0 : 1'b1, 8'($urandom), $urandom,
                   $urandom_range(LAT, LAT + 6));
      end
      rdy_pct = 100;
      repeat (DEPTH + 2) cycle();
      check("final_drain", fifo_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1);
   end
endmodule
